// File: rtl/irq_source_dev.sv
`default_nettype none
// ============================================================================
// Module   : irq_source_dev
// Brief    : Memory-mapped interrupt source with a countdown timer and a
//            PC-match trigger; raises irq until the handler stores to BASE.
// Revision : 1.0 - initial release
// ============================================================================
module irq_source_dev #(
    parameter logic [31:0] BASE = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dev_addr,
    input  logic [3:0]  dev_byteen,
    input  logic [31:0] dev_wdata,
    output logic [31:0] dev_rdata,
    input  logic [31:0] macroscopic_pc,
    output logic        irq
);

    localparam logic [29:0] c_base_word   = BASE[31:2];
    localparam logic [2:0]  c_off_status  = 3'd0;
    localparam logic [2:0]  c_off_ctrl    = 3'd1;
    localparam logic [2:0]  c_off_preset  = 3'd2;
    localparam logic [2:0]  c_off_count   = 3'd3;
    localparam logic [2:0]  c_off_match   = 3'd4;

    localparam logic [1:0]  c_st_idle     = 2'd0;
    localparam logic [1:0]  c_st_cnt      = 2'd1;
    localparam logic [1:0]  c_st_pend     = 2'd2;

    logic [29:0] w_word;
    logic        w_hit;
    logic        w_wr;
    logic        w_ack;
    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_match_wr;
    logic        w_ten_off;
    logic [2:0]  w_ctrl_wval;
    logic [31:0] w_preset_wval;
    logic [31:0] w_match_wval;
    logic [31:0] w_pc_al;
    logic        w_pc_fire;
    logic        w_timer_fire;
    logic        w_clr_ten;
    logic [31:0] w_count_next;
    logic [1:0]  w_state_next;
    logic        w_unused_bits;

    logic [1:0]  r_state;
    logic [1:0]  r_status;
    logic [2:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [31:0] r_match;
    logic [31:0] r_prev_pc;

    function automatic logic [31:0] f_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // Addresses below BASE wrap to large word offsets and miss the window.
    assign w_word        = dev_addr[31:2] - c_base_word;
    assign w_hit         = (w_word < 30'd5);
    assign w_wr          = w_hit && (dev_byteen != 4'b0000);
    assign w_ack         = w_wr && (w_word[2:0] == c_off_status);
    assign w_ctrl_wr     = w_wr && (w_word[2:0] == c_off_ctrl);
    assign w_preset_wr   = w_wr && (w_word[2:0] == c_off_preset);
    assign w_match_wr    = w_wr && (w_word[2:0] == c_off_match);

    assign w_ctrl_wval   = dev_byteen[0] ? dev_wdata[2:0] : r_ctrl;
    assign w_preset_wval = f_merge(r_preset, dev_wdata, dev_byteen);
    assign w_match_wval  = f_merge(r_match, dev_wdata, dev_byteen) & 32'hFFFF_FFFC;
    assign w_ten_off     = w_ctrl_wr && !w_ctrl_wval[0];

    assign w_pc_al       = {macroscopic_pc[31:2], 2'b00};
    assign w_pc_fire     = r_ctrl[2] && (w_pc_al == r_match) && (r_prev_pc != r_match);
    assign w_unused_bits = ^{dev_addr[1:0], macroscopic_pc[1:0]};

    // Timer state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timer next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_ctrl_wr && w_ctrl_wval[0]) begin
                    w_state_next = c_st_cnt;
                end
            end
            c_st_cnt: begin
                if (w_ten_off) begin
                    w_state_next = c_st_idle;
                end else if (!w_preset_wr && (r_count == 32'd0)) begin
                    w_state_next = c_st_pend;
                end
            end
            c_st_pend: begin
                if (w_ten_off) begin
                    w_state_next = c_st_idle;
                end else if (w_ack) begin
                    w_state_next = r_ctrl[1] ? c_st_cnt : c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Timer outputs: count update, fire strobe and one-shot disable
    always_comb begin
        w_count_next = r_count;
        w_timer_fire = 1'b0;
        w_clr_ten    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_ctrl_wr && w_ctrl_wval[0]) begin
                    w_count_next = r_preset;
                end
            end
            c_st_cnt: begin
                if (w_ten_off) begin
                    w_count_next = r_count;
                end else if (w_preset_wr) begin
                    w_count_next = w_preset_wval;
                end else if (r_count == 32'd0) begin
                    w_timer_fire = 1'b1;
                end else begin
                    w_count_next = r_count - 32'd1;
                end
            end
            c_st_pend: begin
                if (!w_ten_off && w_ack) begin
                    if (r_ctrl[1]) begin
                        w_count_next = r_preset;
                    end else begin
                        w_clr_ten = 1'b1;
                    end
                end
            end
            default: w_count_next = r_count;
        endcase
    end

    // Register file; a set event in the ACK cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_status  <= 2'b00;
            r_ctrl    <= 3'b000;
            r_preset  <= 32'd0;
            r_count   <= 32'd0;
            r_match   <= 32'd0;
            r_prev_pc <= 32'd0;
        end else begin
            r_status[0] <= w_timer_fire | (r_status[0] & ~w_ack);
            r_status[1] <= w_pc_fire | (r_status[1] & ~w_ack);
            if (w_ctrl_wr) begin
                r_ctrl <= w_ctrl_wval;
            end else if (w_clr_ten) begin
                r_ctrl[0] <= 1'b0;
            end
            if (w_preset_wr) begin
                r_preset <= w_preset_wval;
            end
            if (w_match_wr) begin
                r_match <= w_match_wval;
            end
            r_count   <= w_count_next;
            r_prev_pc <= w_pc_al;
        end
    end

    always_comb begin
        dev_rdata = 32'd0;
        if (w_hit) begin
            case (w_word[2:0])
                c_off_status: dev_rdata = {30'd0, r_status};
                c_off_ctrl:   dev_rdata = {29'd0, r_ctrl};
                c_off_preset: dev_rdata = r_preset;
                c_off_count:  dev_rdata = r_count;
                c_off_match:  dev_rdata = r_match;
                default:      dev_rdata = 32'd0;
            endcase
        end
    end

    assign irq = |r_status;

endmodule
`default_nettype wire

// File: tb/tb_irq_source_dev.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_source_dev
// Brief    : Directed self-checking bench for irq_source_dev.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_source_dev;

    localparam logic [31:0] c_status = 32'h7F20;
    localparam logic [31:0] c_ctrl   = 32'h7F24;
    localparam logic [31:0] c_preset = 32'h7F28;
    localparam logic [31:0] c_count  = 32'h7F2C;
    localparam logic [31:0] c_match  = 32'h7F30;

    logic        clk;
    logic        reset;
    logic [31:0] dev_addr;
    logic [3:0]  dev_byteen;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic [31:0] macroscopic_pc;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int seen;

    irq_source_dev #(.BASE(32'h0000_7F20)) dut (
        .clk            (clk),
        .reset          (reset),
        .dev_addr       (dev_addr),
        .dev_byteen     (dev_byteen),
        .dev_wdata      (dev_wdata),
        .dev_rdata      (dev_rdata),
        .macroscopic_pc (macroscopic_pc),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dev_addr   = a;
        dev_wdata  = d;
        dev_byteen = be;
        tick();
        dev_byteen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        dev_addr   = a;
        dev_byteen = 4'b0000;
        #1;
        chk(tag, dev_rdata, exp);
    endtask

    task automatic idle_count_irq(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (irq) hits++;
        end
    endtask

    initial begin
        reset          = 1'b0;
        dev_addr       = 32'd0;
        dev_byteen     = 4'b0000;
        dev_wdata      = 32'd0;
        macroscopic_pc = 32'd0;

        // Reset with random bus traffic
        for (int i = 0; i < 3; i++) begin
            dev_addr       = c_status + 32'(4 * $urandom_range(0, 4));
            dev_wdata      = $urandom;
            dev_byteen     = 4'($urandom_range(0, 15));
            macroscopic_pc = $urandom;
            tick();
            chk("reset_irq", {31'd0, irq}, 32'd0);
        end
        reset          = 1'b1;
        macroscopic_pc = 32'd0;
        rd(c_status, 32'd0, "rst_status");
        rd(c_ctrl,   32'd0, "rst_ctrl");
        rd(c_preset, 32'd0, "rst_preset");
        rd(c_count,  32'd0, "rst_count");
        rd(c_match,  32'd0, "rst_match");
        rd(32'h7F34, 32'd0, "rst_outside");
        chk("rst_irq2", {31'd0, irq}, 32'd0);

        // One-shot timer, PRESET=3
        wr(c_preset, 32'd3, 4'hF);
        wr(c_ctrl, 32'd1, 4'hF);
        rd(c_count, 32'd3, "os_cnt3");
        tick(); rd(c_count, 32'd2, "os_cnt2");
        tick(); rd(c_count, 32'd1, "os_cnt1");
        tick(); rd(c_count, 32'd0, "os_cnt0");
        chk("os_irq_e3", {31'd0, irq}, 32'd0);
        tick();
        chk("os_irq_e4", {31'd0, irq}, 32'd1);
        rd(c_status, 32'd1, "os_status");
        tick(); tick();
        chk("os_irq_hold", {31'd0, irq}, 32'd1);
        wr(c_status, 32'hFFFF_FFFF, 4'hF);
        chk("os_irq_ack", {31'd0, irq}, 32'd0);
        rd(c_ctrl, 32'd0, "os_ctrl_cleared");
        idle_count_irq(20, seen);
        chk("os_no_refire", 32'(seen), 32'd0);

        // Periodic timer, PRESET=2
        wr(c_preset, 32'd2, 4'hF);
        wr(c_ctrl, 32'd3, 4'hF);
        tick(); tick();
        chk("per_irq_e2", {31'd0, irq}, 32'd0);
        tick();
        chk("per_irq_e3", {31'd0, irq}, 32'd1);
        wr(c_status, 32'd0, 4'h1);
        chk("per_ack_irq", {31'd0, irq}, 32'd0);
        rd(c_count, 32'd2, "per_reload");
        tick(); tick();
        chk("per_irq_e2b", {31'd0, irq}, 32'd0);
        tick();
        chk("per_irq_e3b", {31'd0, irq}, 32'd1);
        rd(c_status, 32'd1, "per_status");
        wr(c_status, 32'd0, 4'h1);
        wr(c_ctrl, 32'd2, 4'h1);
        rd(c_ctrl, 32'd2, "per_ctrl_off");
        rd(c_count, 32'd2, "per_count_hold");
        idle_count_irq(10, seen);
        chk("per_stopped", 32'(seen), 32'd0);

        // PC match, edge-triggered
        wr(c_match, 32'h0000_3010, 4'hF);
        wr(c_ctrl, 32'd4, 4'hF);
        macroscopic_pc = 32'h0000_300C;
        tick();
        chk("pc_pre", {31'd0, irq}, 32'd0);
        macroscopic_pc = 32'h0000_3010;
        tick();
        chk("pc_fire_irq", {31'd0, irq}, 32'd1);
        rd(c_status, 32'd2, "pc_status");
        tick(); tick();
        macroscopic_pc = 32'h0000_3013;
        tick(); tick();
        rd(c_status, 32'd2, "pc_status_hold");
        wr(c_match, 32'h0000_3013, 4'hF);
        rd(c_match, 32'h0000_3010, "pc_match_lsb");
        macroscopic_pc = 32'h0000_3010;
        wr(c_status, 32'd0, 4'h8);
        chk("pc_ack_irq", {31'd0, irq}, 32'd0);
        tick(); tick(); tick();
        rd(c_status, 32'd0, "pc_no_refire");

        // ACK collision with PRESET=0 periodic
        macroscopic_pc = 32'h0000_3000;
        wr(c_preset, 32'd0, 4'hF);
        wr(c_ctrl, 32'd7, 4'hF);
        tick();
        rd(c_status, 32'd1, "col_fire");
        wr(c_status, 32'd0, 4'h1);
        rd(c_status, 32'd0, "col_ack");
        wr(c_status, 32'd0, 4'h1);
        rd(c_status, 32'd1, "col_set_wins");
        wr(c_status, 32'd0, 4'h1);
        rd(c_status, 32'd0, "col_ack2");
        macroscopic_pc = 32'h0000_3010;
        wr(c_status, 32'd0, 4'h1);
        rd(c_status, 32'd3, "col_both");
        wr(c_ctrl, 32'd0, 4'h1);
        rd(c_status, 32'd3, "col_ctrl_off_keeps");
        chk("col_irq", {31'd0, irq}, 32'd1);
        wr(c_status, 32'd0, 4'h1);
        rd(c_status, 32'd0, "col_final_ack");

        // Partial writes, then reset mid-count
        wr(c_preset, 32'h1234_56AB, 4'b0001);
        rd(c_preset, 32'h0000_00AB, "pw_byte0");
        wr(c_preset, 32'h00CD_0000, 4'b0100);
        rd(c_preset, 32'h00CD_00AB, "pw_byte2");
        wr(c_ctrl, 32'h0000_0001, 4'b0001);
        tick(); tick();
        rd(c_count, 32'h00CD_00A9, "pw_counting");
        reset = 1'b0;
        tick();
        rd(c_count,  32'd0, "mr_count");
        rd(c_preset, 32'd0, "mr_preset");
        rd(c_ctrl,   32'd0, "mr_ctrl");
        rd(c_status, 32'd0, "mr_status");
        chk("mr_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        idle_count_irq(20, seen);
        chk("mr_no_irq", 32'(seen), 32'd0);
        rd(c_count, 32'd0, "mr_count_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
